pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline-stage register for the risc_v core. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
//  Carries an opaque data payload plus a control field through a valid/ready handshake, adding back-pressure (stall) and flush (bubble insertion).
//  The control field carries the write-enable / wb-select class signals. It is cleared on flush and masked on bubbles, so a killed instruction never commits.
//  Sits between any two pipeline stages; one instance per stage boundary.
// PARAMETERS
//  DATA_WIDTH  128  payload bits (alu_out, data_out, dataB, opcode, rs1/rs2/rd ...); never cleared by flush
//  CTRL_WIDTH  2    control bits (reg_write_en, wb_sel ...); cleared by flush, masked when invalid
// PORTS
//  clk        in   1           clock, rising edge
//  reset_n    in   1           asynchronous reset, active-low
//  flush      in   1           synchronous kill of all held entries (branch/exception)
//  in_valid   in   1           upstream entry present
//  in_ready   out  1           stage can accept this cycle
//  in_data    in   DATA_WIDTH  upstream payload
//  in_ctrl    in   CTRL_WIDTH  upstream control
//  out_valid  out  1           head entry present
//  out_ready  in   1           downstream accepts head this cycle
//  out_data   out  DATA_WIDTH  head payload
//  out_ctrl   out  CTRL_WIDTH  head control, forced 0 when out_valid=0
//  occupancy  out  2           number of held entries (0..2)
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (async, reset_n=0): state EMPTY. All data/ctrl regs 0. out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
//    in_ready=1 from the first cycle after reset release.
//  - Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N and can leave at edge N+1.
//  - Storage: main reg (head) + skid reg. FSM states EMPTY / ONE / TWO; occupancy = 0/1/2.
//    EMPTY: in_fire -> ONE, main<=in.
//    ONE:   in_fire & out_fire -> ONE, main<=in. in_fire only -> TWO, skid<=in. out_fire only -> EMPTY.
//    TWO:   in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
//  - in_ready is a pure register output: 1 iff next state != TWO. There is no combinational path out_ready->in_ready.
//  - Sustained in_valid=out_ready=1 gives 1 entry/cycle, with no bubbles.
//  - out_data/out_ctrl stay stable while out_valid=1 & out_ready=0 (AXI-style hold).
//  - Flush has the highest priority. At the flush edge: state->EMPTY and ctrl of main and skid <= 0. Data regs keep their values.
//    Any in_fire and out_fire in the flush cycle are discarded. The downstream must ignore an out_fire in that cycle.
//    Next cycle: out_valid=0 and in_ready=1.
//  - Flush with reset asserted: reset wins.
//  - Reset mid-operation drops all entries immediately.
//  - Width rules: payload copied verbatim, no truncation. out_ctrl = main_ctrl & {CTRL_WIDTH{out_valid}}.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: 2-entry skid behaviour as above; registered in_ready; occupancy 0..2.
//  Not defined: single main reg, no skid, states EMPTY/ONE only.
//    in_ready = ~out_valid | out_ready, a combinational path from out_ready.
//    occupancy max 1. Full throughput is still kept; flush, reset and masking rules are unchanged.
// TESTING
//  T1 reset: reset_n=0 mid-stream with 2 entries held -> out_valid=0, out_ctrl=0, occupancy=0 immediately; in_ready=1 after release.
//  T2 streaming: in_valid=1, out_ready=1, data 0x1..0x20 for 32 cycles -> out_data 0x1..0x20 in order, one per cycle, 1-cycle latency.
//  T3 back-pressure: push 0xA, 0xB with out_ready=0 -> occupancy=2 and in_ready=0; 0xC is held off.
//     Release out_ready -> output is 0xA, 0xB, 0xC with no loss or duplication (skid build).
//  T4 flush: occupancy=2, ctrl=2'b11, flush=1 with in_valid=1 (0xD) -> next cycle out_valid=0, out_ctrl=0, occupancy=0.
//     0xD never appears.
//  T5 hold stability: out_valid=1, out_ready=0 for 10 cycles while in_data toggles -> out_data/out_ctrl unchanged.
//  T6 random valid/ready/flush for 10k cycles vs scoreboard -> order preserved, no ctrl!=0 while out_valid=0; run with and without PIPE_STAGE_SKID_EN.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline-stage register with flush and ctrl masking.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid variant with a registered in_ready.
//
// state   | meaning
// S_EMPTY | no entry held
// S_ONE   | head entry in main reg
// S_TWO   | main and skid regs both full (skid build only)
module pipe_stage_elastic #(
   parameter int DATA_WIDTH = 128,
   parameter int CTRL_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [1:0]            occupancy
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
   logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
   logic                  in_fire, out_fire;

`ifdef PIPE_STAGE_SKID_EN
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
   logic                  in_ready_q, in_ready_d;

   assign in_ready = in_ready_q;
`else
   assign in_ready = ~out_valid | out_ready;
`endif

   assign out_valid = (state_q != S_EMPTY);
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q & {CTRL_WIDTH{out_valid}};
   assign occupancy = state_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
`endif
      if (flush) begin
         // payload regs are left alone; only ctrl must die so nothing commits
         state_d     = S_EMPTY;
         main_ctrl_d = '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_ctrl_d = '0;
`endif
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  state_d     = S_ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            S_ONE: begin
               if (in_fire && out_fire) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
               end else if (in_fire) begin
                  state_d     = S_TWO;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
`endif
               end else if (out_fire) begin
                  state_d = S_EMPTY;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            S_TWO: begin
               if (out_fire) begin
                  state_d     = S_ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
               end
            end
`endif
            default: state_d = S_EMPTY;
         endcase
      end
`ifdef PIPE_STAGE_SKID_EN
      in_ready_d = (state_d != S_TWO);
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= in_ready_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus a random run
// against a queue-based model of the stage.
module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct packed {
      logic [127:0] d;
      logic [1:0]   c;
   } ent_t;

   logic         clk = 1'b0;
   logic         reset_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_data, out_data;
   logic [1:0]   in_ctrl, out_ctrl, occupancy;

   ent_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   pipe_stage_elastic dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic model_in_ready();
`ifdef PIPE_STAGE_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || out_ready;
`endif
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive(input logic iv, input logic [127:0] d, input logic [1:0] c,
                        input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Advance one clock edge and apply the same transfer to the model.
   task automatic advance();
      logic fi, fo;
      fi = in_valid && model_in_ready();
      fo = (q.size() > 0) && out_ready;
      @(posedge clk);
      if (!reset_n || flush) q.delete();
      else begin
         if (fo) void'(q.pop_front());
         if (fi) q.push_back('{d: in_data, c: in_ctrl});
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(0, '0, '0, 0, 0);
      repeat (3) @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
      n_checks++; if (out_data !== 128'h0) $display("FAIL reset_out_data: got %h exp 0", out_data); else n_pass++;
      n_checks++; if (out_ctrl !== 2'b00) $display("FAIL reset_out_ctrl: got %b exp 00", out_ctrl); else n_pass++;
      n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d exp 0", occupancy); else n_pass++;
      reset_n = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else n_pass++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         drive(1, 128'h11 + i, 2'b11, 0, 0);
         advance();
      end
      drive(0, '0, '0, 0, 0);
      #1;
      n_checks++; if (occupancy !== 2'(CAP)) $display("FAIL reset_fill_occ: got %0d exp %0d", occupancy, CAP); else n_pass++;
      reset_n = 1'b0;
      q.delete();
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_mid_valid: got %b exp 0", out_valid); else n_pass++;
      n_checks++; if (out_ctrl !== 2'b00) $display("FAIL reset_mid_ctrl: got %b exp 00", out_ctrl); else n_pass++;
      n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_mid_occ: got %0d exp 0", occupancy); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_rel_in_ready: got %b exp 1", in_ready); else n_pass++;
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 33; i++) begin
         drive(i <= 32, 128'(i), 2'(i), 1, 0);
         #1;
         n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready cyc %0d: got %b exp 1", i, in_ready); else n_pass++;
         n_checks++; if (out_valid !== (i > 1)) $display("FAIL stream_valid cyc %0d: got %b exp %b", i, out_valid, i > 1); else n_pass++;
         if (i > 1) begin
            n_checks++; if (out_data !== 128'(i - 1)) $display("FAIL stream_data cyc %0d: got %h exp %h", i, out_data, 128'(i - 1)); else n_pass++;
            n_checks++; if (out_ctrl !== 2'(i - 1)) $display("FAIL stream_ctrl cyc %0d: got %b exp %b", i, out_ctrl, 2'(i - 1)); else n_pass++;
         end
         advance();
      end
      drive(0, '0, '0, 1, 0);
      advance();
   endtask

   task automatic test_back_pressure();
      logic [127:0] items[3];
      logic [127:0] got[$];
      int idx = 0;
      items[0] = 128'hA; items[1] = 128'hB; items[2] = 128'hC;
      for (int k = 0; k < 4; k++) begin
         drive(1, items[idx], 2'b01, 0, 0);
         #1;
         if (model_in_ready()) begin advance(); idx++; end
         else advance();
      end
      #1;
      n_checks++; if (occupancy !== 2'(CAP)) $display("FAIL bp_occ: got %0d exp %0d", occupancy, CAP); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b exp 0", in_ready); else n_pass++;
      n_checks++; if (out_data !== 128'hA) $display("FAIL bp_head: got %h exp a", out_data); else n_pass++;
      n_checks++; if (idx !== CAP) $display("FAIL bp_accepted: got %0d exp %0d", idx, CAP); else n_pass++;
      for (int k = 0; k < 10; k++) begin
         drive(idx < 3, (idx < 3) ? items[idx] : 128'h0, 2'b01, 1, 0);
         #1;
         if (out_valid) got.push_back(out_data);
         if (idx < 3 && model_in_ready()) begin advance(); idx++; end
         else advance();
      end
      n_checks++; if (got.size() !== 3) $display("FAIL bp_count: got %0d exp 3", got.size()); else n_pass++;
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         n_checks++; if (got[k] !== items[k]) $display("FAIL bp_order %0d: got %h exp %h", k, got[k], items[k]); else n_pass++;
      end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 2; k++) begin
         drive(1, 128'h1 + k, 2'b11, 0, 0);
         advance();
      end
      #1;
      n_checks++; if (out_ctrl !== 2'b11) $display("FAIL flush_pre_ctrl: got %b exp 11", out_ctrl); else n_pass++;
      drive(1, 128'hD, 2'b11, 1, 1);
      advance();
      drive(0, '0, '0, 1, 0);
      #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b exp 0", out_valid); else n_pass++;
      n_checks++; if (out_ctrl !== 2'b00) $display("FAIL flush_ctrl: got %b exp 00", out_ctrl); else n_pass++;
      n_checks++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d exp 0", occupancy); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b exp 1", in_ready); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         advance();
         n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_d %0d: got valid %b data %h exp valid 0", k, out_valid, out_data); else n_pass++;
      end
   endtask

   task automatic test_hold();
      drive(1, 128'h55, 2'b10, 0, 0);
      advance();
      for (int k = 0; k < 10; k++) begin
         drive(1, rnd128(), 2'($urandom()), 0, 0);
         #1;
         n_checks++; if (out_data !== 128'h55) $display("FAIL hold_data %0d: got %h exp 55", k, out_data); else n_pass++;
         n_checks++; if (out_ctrl !== 2'b10) $display("FAIL hold_ctrl %0d: got %b exp 10", k, out_ctrl); else n_pass++;
         advance();
      end
      drive(0, '0, '0, 0, 1);
      advance();
   endtask

   task automatic test_random();
      logic         ev;
      logic [1:0]   ec;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         drive($urandom_range(0, 3) != 0, rnd128(), 2'($urandom()),
               $urandom_range(0, 2) != 0, $urandom_range(0, 99) < 3);
         #1;
         ev = q.size() > 0;
         ec = ev ? q[0].c : 2'b00;
         n_checks++; if (out_valid !== ev) $display("FAIL rnd_valid cyc %0d: got %b exp %b", cyc, out_valid, ev); else n_pass++;
         n_checks++; if (out_ctrl !== ec) $display("FAIL rnd_ctrl cyc %0d: got %b exp %b", cyc, out_ctrl, ec); else n_pass++;
         n_checks++; if (occupancy !== 2'(q.size())) $display("FAIL rnd_occ cyc %0d: got %0d exp %0d", cyc, occupancy, q.size()); else n_pass++;
         n_checks++; if (in_ready !== model_in_ready()) $display("FAIL rnd_in_ready cyc %0d: got %b exp %b", cyc, in_ready, model_in_ready()); else n_pass++;
         if (ev) begin
            n_checks++; if (out_data !== q[0].d) $display("FAIL rnd_data cyc %0d: got %h exp %h", cyc, out_data, q[0].d); else n_pass++;
         end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
